ise_pixel_source: RTL and testbench
===================================

// Module: ise_pixel_source
// PURPOSE
// - Transmit end of the ISE pixel interface: streams num_images images pixel-by-pixel from a
//   synchronous pixel memory into the ISE core (image_in_index/pixel_in), honouring the core's busy.
// - Also counts the core's sorted-result strobes (out_valid) and flags completion.
// - Sits beside ISE in the test system, between pixel memory and ISE inputs/outputs.
// PARAMETERS
// - PIX_PER_IMG  16384  pixels per image; power of two, >= 2
// - PIX_W        14     log2(PIX_PER_IMG)
// - AW           19     mem_addr width = 5 + PIX_W
// PORTS
// - clk            in   1   rising-edge clock
// - reset          in   1   asynchronous, active-low reset
// - start          in   1   1-cycle pulse; ignored unless state==IDLE or DONE
// - num_images     in   5   images to send, sampled on accepted start; 0 means 32
// - mem_rd         out  1   memory read strobe
// - mem_addr       out  AW  {image, pixel} linear address, valid with mem_rd
// - mem_rdata      in   24  {R,G,B}; valid exactly 1 cycle after mem_rd
// - busy           in   1   from ISE; 1 = do not transfer
// - pixel_valid    out  1   qualifies pixel_in/image_in_index
// - pixel_in       out  24  pixel to ISE
// - image_in_index out  5   image number of pixel_in
// - out_valid      in   1   ISE result strobe
// - result_cnt     out  6   out_valid pulses counted since start (0..32)
// - active         out  1   1 in PRIME/STREAM/DRAIN
// - done           out  1   all pixels transferred and result_cnt==N; held until next start
// - overflow_err   out  1   sticky: out_valid seen while result_cnt==N; cleared on start
// BEHAVIOUR
// - Reset (async, reset=0): all outputs 0, state IDLE, counters 0, skid buffer empty.
// - Reset mid-operation aborts immediately; reads in flight are discarded.
// - Transfer rule: a pixel is consumed on a rising edge with pixel_valid=1 && busy=0.
//   While pixel_valid=1 && busy=1, pixel_in and image_in_index hold stable.
// - No drop, duplicate or reorder; pixels leave in address order 0..N*PIX_PER_IMG-1.
// - N = (num_images==0) ? 32 : num_images; captured on accepted start.
// - FSM:
//   - IDLE/DONE -start-> PRIME: clears counters, done and overflow_err.
//   - PRIME -first word in buffer-> STREAM.
//   - STREAM -last address issued-> DRAIN.
//   - DRAIN -last pixel consumed && result_cnt==N-> DONE.
//   - DRAIN -last pixel consumed && result_cnt<N-> stays DRAIN with pixel_valid=0 until
//     result_cnt==N, then DONE.
// - Latency: start at edge T -> mem_rd=1, addr 0 in cycle T+1 -> pixel_valid=1 in cycle T+2.
// - Throughput: 1 pixel/cycle with busy=0 continuously; no bubbles after the first.
// - Skid buffer: 2 entries. mem_rd=1 only if (buffered + in_flight - consumed_this_cycle) < 2
//   and addresses remain. The cycle after the last consume with buffer empty, pixel_valid=0.
// - Address counter: pixel field wraps PIX_PER_IMG-1 -> 0 and increments the image field.
//   image_in_index comes from the buffered word's address, so it changes on the same cycle as
//   the first pixel of the next image.
// - result_cnt increments on out_valid only in STREAM/DRAIN/DONE and saturates at N.
//   out_valid in IDLE/PRIME is ignored.
// - Simultaneous start and out_valid in DONE: start wins and result_cnt becomes 0.
// - done asserts in the cycle after entering DONE.
// TESTING
// - Reset: drive reset=0 mid-cycle -> all outputs 0 asynchronously; no mem_rd until start.
// - PIX_PER_IMG=4, num_images=2, busy=0, mem_rdata=addr -> pixel_in 0..7 on 8 consecutive
//   cycles, image_in_index 0,0,0,0,1,1,1,1, exactly 8 mem_rd.
// - Same setup, busy random 50% -> identical consumed sequence; pixel_in stable on busy cycles.
// - After stream, 2 out_valid pulses -> done=1 the cycle after DONE entry; 3rd pulse
//   -> overflow_err=1, result_cnt stays 2.
// - reset=0 after pixel 3 consumed, then restart -> first consumed pixel is address 0.
// - num_images=0 -> 32*PIX_PER_IMG pixels consumed; last has image_in_index=31.

Source files
------------

// File: rtl/ise_pixel_source.sv
`default_nettype none
// ============================================================================
// Module      : ise_pixel_source
// Description : Transmit side of the ISE pixel interface. Reads num_images
//               images pixel-by-pixel from a synchronous pixel memory and
//               streams them into the ISE core, honouring busy through a
//               2-entry fall-through skid buffer. It also counts the core's
//               out_valid result strobes and flags completion.
// Ports       : clk, reset (async, active-low)
//               start, num_images           - run control (0 images = 32)
//               mem_rd, mem_addr, mem_rdata - pixel memory (1-cycle latency)
//               busy, pixel_valid, pixel_in, image_in_index - ISE input side
//               out_valid, result_cnt       - ISE result strobes and count
//               active, done, overflow_err  - status
// Revision    : 1.0 - initial release
// ============================================================================
module ise_pixel_source #(
    parameter int PIX_PER_IMG = 16384,
    parameter int PIX_W       = 14,
    parameter int AW          = 19
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [4:0]    num_images,
    output logic          mem_rd,
    output logic [AW-1:0] mem_addr,
    input  logic [23:0]   mem_rdata,
    input  logic          busy,
    output logic          pixel_valid,
    output logic [23:0]   pixel_in,
    output logic [4:0]    image_in_index,
    input  logic          out_valid,
    output logic [5:0]    result_cnt,
    output logic          active,
    output logic          done,
    output logic          overflow_err
);

    localparam logic [2:0] c_ST_IDLE   = 3'd0;
    localparam logic [2:0] c_ST_PRIME  = 3'd1;
    localparam logic [2:0] c_ST_STREAM = 3'd2;
    localparam logic [2:0] c_ST_DRAIN  = 3'd3;
    localparam logic [2:0] c_ST_DONE   = 3'd4;

    localparam logic [PIX_W-1:0] c_PIX_LAST = PIX_W'(PIX_PER_IMG - 1);

    // Buffer entry: {image index, pixel data}
    localparam int c_ENT_W = 5 + 24;

    logic [2:0]         r_state;
    logic [2:0]         w_state_next;
    logic [PIX_W-1:0]   r_pix;
    logic [4:0]         r_img;
    logic [4:0]         r_last_img;
    logic [5:0]         r_n;
    logic               r_all_issued;
    logic               r_rd_q;
    logic [4:0]         r_rd_img;
    logic [1:0]         r_cnt;
    logic [c_ENT_W-1:0] r_ent0;
    logic [c_ENT_W-1:0] r_ent1;
    logic [5:0]         r_result_cnt;
    logic               r_done;
    logic               r_ovf;

    logic               w_start_ok;
    logic               w_consume;
    logic [2:0]         w_occ_after;
    logic               w_issue_state;
    logic               w_count_state;
    logic               w_mem_rd;
    logic               w_last_addr;
    logic               w_drained;
    logic               w_push;
    logic               w_pop;
    logic               w_buf_nonempty;
    logic [c_ENT_W-1:0] w_incoming;
    logic [c_ENT_W-1:0] w_head;

    assign w_start_ok     = start && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
    assign w_buf_nonempty = (r_cnt != 2'd0);

    // The word returning from memory this cycle is presented directly when the
    // buffer is empty, which gives pixel_valid two cycles after start.
    assign w_incoming  = {r_rd_img, mem_rdata};
    assign w_head      = w_buf_nonempty ? r_ent0 : w_incoming;
    assign pixel_valid = w_buf_nonempty || r_rd_q;
    assign w_consume   = pixel_valid && !busy;

    // Words held after this edge: buffered + arriving - leaving. Keeping it
    // below 2 before issuing guarantees the new read always has a slot.
    assign w_occ_after   = {1'b0, r_cnt} + {2'b00, r_rd_q} - {2'b00, w_consume};
    assign w_issue_state = (r_state == c_ST_PRIME) || (r_state == c_ST_STREAM);
    assign w_count_state = (r_state == c_ST_STREAM) || (r_state == c_ST_DRAIN) ||
                           (r_state == c_ST_DONE);
    assign w_mem_rd      = w_issue_state && !r_all_issued && (w_occ_after < 3'd2);
    assign w_last_addr   = w_mem_rd && (r_img == r_last_img) && (r_pix == c_PIX_LAST);
    assign w_drained     = (w_occ_after == 3'd0);

    // A word that is both arriving and consumed in the same cycle bypasses
    // the buffer entirely.
    assign w_push = r_rd_q && !(!w_buf_nonempty && w_consume);
    assign w_pop  = w_consume && w_buf_nonempty;

    assign mem_rd         = w_mem_rd;
    assign mem_addr       = w_mem_rd ? AW'({r_img, r_pix}) : '0;
    assign pixel_in       = pixel_valid ? w_head[23:0]  : 24'd0;
    assign image_in_index = pixel_valid ? w_head[28:24] : 5'd0;
    assign result_cnt     = r_result_cnt;
    assign active         = (r_state == c_ST_PRIME) || (r_state == c_ST_STREAM) ||
                            (r_state == c_ST_DRAIN);
    assign done           = r_done;
    assign overflow_err   = r_ovf;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) w_state_next = c_ST_PRIME;
            end
            c_ST_PRIME: begin
                if (r_rd_q) begin
                    w_state_next = (r_all_issued || w_last_addr) ? c_ST_DRAIN : c_ST_STREAM;
                end
            end
            c_ST_STREAM: begin
                if (w_last_addr) w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (w_drained && (r_result_cnt == r_n)) w_state_next = c_ST_DONE;
            end
            c_ST_DONE: begin
                if (w_start_ok) w_state_next = c_ST_PRIME;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // Control, address generation and result accounting
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= c_ST_IDLE;
            r_pix        <= '0;
            r_img        <= '0;
            r_last_img   <= '0;
            r_n          <= '0;
            r_all_issued <= 1'b0;
            r_rd_q       <= 1'b0;
            r_rd_img     <= '0;
            r_result_cnt <= '0;
            r_done       <= 1'b0;
            r_ovf        <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_rd_q  <= w_mem_rd;

            if (w_start_ok) begin
                r_pix        <= '0;
                r_img        <= '0;
                // 0 - 1 wraps to 31, matching the "0 means 32" encoding
                r_last_img   <= num_images - 5'd1;
                r_n          <= (num_images == 5'd0) ? 6'd32 : {1'b0, num_images};
                r_all_issued <= 1'b0;
            end else if (w_mem_rd) begin
                r_rd_img     <= r_img;
                r_all_issued <= r_all_issued || w_last_addr;
                if (r_pix == c_PIX_LAST) begin
                    r_pix <= '0;
                    r_img <= r_img + 5'd1;
                end else begin
                    r_pix <= r_pix + 1'b1;
                end
            end

            // start takes priority over a coincident out_valid in DONE
            if (w_start_ok) begin
                r_result_cnt <= '0;
                r_ovf        <= 1'b0;
            end else if (out_valid && w_count_state) begin
                if (r_result_cnt == r_n) begin
                    r_ovf <= 1'b1;
                end else begin
                    r_result_cnt <= r_result_cnt + 6'd1;
                end
            end

            if (w_start_ok) begin
                r_done <= 1'b0;
            end else if (r_state == c_ST_DONE) begin
                r_done <= 1'b1;
            end
        end
    end

    // Two-entry skid buffer; r_ent0 is always the head
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_ent0 <= '0;
            r_ent1 <= '0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_ent0 <= w_incoming;
                    else               r_ent1 <= w_incoming;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_ent0 <= r_ent1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_ent0 <= w_incoming;
                    end else begin
                        r_ent0 <= r_ent1;
                        r_ent1 <= w_incoming;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ise_pixel_source.sv
`default_nettype none
// ============================================================================
// Module      : tb_ise_pixel_source
// Description : Self-checking bench for ise_pixel_source with 4-pixel images.
//               The memory model returns each word's own address as data.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ise_pixel_source;

    localparam int PPI = 4;
    localparam int PW  = 2;
    localparam int AWB = 7;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           start = 1'b0;
    logic [4:0]     num_images = 5'd0;
    logic           mem_rd;
    logic [AWB-1:0] mem_addr;
    logic [23:0]    mem_rdata = 24'd0;
    logic           busy = 1'b0;
    logic           pixel_valid;
    logic [23:0]    pixel_in;
    logic [4:0]     image_in_index;
    logic           out_valid = 1'b0;
    logic [5:0]     result_cnt;
    logic           active;
    logic           done;
    logic           overflow_err;

    ise_pixel_source #(.PIX_PER_IMG(PPI), .PIX_W(PW), .AW(AWB)) dut (
        .clk(clk), .reset(reset), .start(start), .num_images(num_images),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .busy(busy), .pixel_valid(pixel_valid), .pixel_in(pixel_in),
        .image_in_index(image_in_index), .out_valid(out_valid),
        .result_cnt(result_cnt), .active(active), .done(done),
        .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data = address, junk when not read
    always @(posedge clk) mem_rdata <= mem_rd ? 24'(mem_addr) : 24'hABCDEF;

    // Monitor: sole writer of the logs below
    int          cons_pix[$];
    int          cons_img[$];
    int          cons_cyc[$];
    int          rd_cyc[$];
    int          stab_err = 0;
    logic        prev_hold = 1'b0;
    logic [23:0] prev_pix = 24'd0;
    logic [4:0]  prev_img = 5'd0;

    always @(negedge clk) begin
        if (mem_rd) rd_cyc.push_back(cyc);
        if (prev_hold && !(pixel_valid && pixel_in == prev_pix && image_in_index == prev_img))
            stab_err = stab_err + 1;
        if (pixel_valid && !busy) begin
            cons_pix.push_back(int'(pixel_in));
            cons_img.push_back(int'(image_in_index));
            cons_cyc.push_back(cyc);
        end
        prev_hold = pixel_valid && busy;
        prev_pix  = pixel_in;
        prev_img  = image_in_index;
    end

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_start(input logic [4:0] n, output int sc);
        @(posedge clk); #1 start = 1'b1; num_images = n;
        @(posedge clk); #1 start = 1'b0;
        sc = cyc;
    endtask

    task automatic pulse_ov();
        @(posedge clk); #1 out_valid = 1'b1;
        @(posedge clk); #1 out_valid = 1'b0;
    endtask

    task automatic wait_consumed(input int base, input int n, input bit rbusy, output int to);
        to = 0;
        while ((cons_pix.size() - base) < n && to < 3000) begin
            @(posedge clk); #1;
            busy = rbusy ? 1'($urandom_range(0, 1)) : 1'b0;
            to++;
        end
        busy = 1'b0;
    endtask

    typedef struct {
        logic [4:0] nimg;
        bit         rbusy;
        int         npix;
        int         nres;
        int         last_img;
    } scen_t;

    scen_t tbl[5];

    initial begin
        int sc, to, bc, br, bs, err, nc;

        tbl[0] = '{5'd2, 1'b0,   8,  2,  1};
        tbl[1] = '{5'd2, 1'b1,   8,  2,  1};
        tbl[2] = '{5'd1, 1'b0,   4,  1,  0};
        tbl[3] = '{5'd3, 1'b1,  12,  3,  2};
        tbl[4] = '{5'd0, 1'b0, 128, 32, 31};

        // Reset state
        #3;
        chk("rst_mem_rd", mem_rd, 0);
        chk("rst_pixel_valid", pixel_valid, 0);
        chk("rst_pixel_in", pixel_in, 0);
        chk("rst_flags", {active, done, overflow_err}, 0);
        chk("rst_result_cnt", result_cnt, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        br = rd_cyc.size();
        pulse_ov();
        repeat (4) @(posedge clk);
        #1;
        chk("idle_no_mem_rd", rd_cyc.size() - br, 0);
        chk("idle_out_valid_ignored", result_cnt, 0);

        foreach (tbl[i]) begin
            bc = cons_pix.size(); br = rd_cyc.size(); bs = stab_err;
            do_start(tbl[i].nimg, sc);
            if (i > 0) chk("start_clears_status", {done, overflow_err}, 0);
            wait_consumed(bc, tbl[i].npix, tbl[i].rbusy, to);
            chk("stream_timeout", (to < 3000), 1);
            repeat (3) @(posedge clk);
            #1;
            nc = cons_pix.size() - bc;
            chk("consumed_count", nc, tbl[i].npix);
            err = 0;
            for (int j = 0; j < nc && j < tbl[i].npix; j++)
                if (cons_pix[bc + j] != j || cons_img[bc + j] != j / PPI) err++;
            chk("order_errors", err, 0);
            if (nc > 0) chk("last_image_index", cons_img[bc + nc - 1], tbl[i].last_img);
            chk("mem_rd_count", rd_cyc.size() - br, tbl[i].npix);
            if (rd_cyc.size() > br) chk("first_mem_rd_cycle", rd_cyc[br], sc);
            chk("hold_stable_errors", stab_err - bs, 0);
            if (!tbl[i].rbusy && nc == tbl[i].npix) begin
                chk("first_valid_latency", cons_cyc[bc], sc + 1);
                chk("no_bubbles", cons_cyc[bc + nc - 1] - cons_cyc[bc], nc - 1);
            end
            chk("drain_wait_state", {done, active, pixel_valid}, 3'b010);
            for (int k = 0; k < tbl[i].nres; k++) pulse_ov();
            to = 0;
            while (!done && to < 20) begin @(posedge clk); #1; to++; end
            chk("done", done, 1);
            chk("result_cnt", result_cnt, tbl[i].nres);
            chk("inactive_when_done", active, 0);
            if (i == 0) begin
                chk("no_overflow_yet", overflow_err, 0);
                pulse_ov();
                @(posedge clk); #1;
                chk("overflow_err", overflow_err, 1);
                chk("result_cnt_saturated", result_cnt, 2);
            end
        end

        // Reset in the middle of a stream, then restart from address 0
        bc = cons_pix.size();
        do_start(5'd2, sc);
        wait_consumed(bc, 4, 1'b0, to);
        chk("pre_reset_timeout", (to < 3000), 1);
        #2 reset = 1'b0;
        #1;
        chk("midrst_mem_rd", mem_rd, 0);
        chk("midrst_pixel_valid", pixel_valid, 0);
        chk("midrst_pixel_in", pixel_in, 0);
        chk("midrst_flags", {active, done, overflow_err}, 0);
        @(negedge clk) reset = 1'b1;
        bc = cons_pix.size();
        do_start(5'd2, sc);
        wait_consumed(bc, 8, 1'b0, to);
        chk("restart_timeout", (to < 3000), 1);
        if (cons_pix.size() > bc) chk("restart_first_pixel", cons_pix[bc], 0);
        repeat (3) @(posedge clk);
        #1;
        chk("restart_count", cons_pix.size() - bc, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
